regfile_mp: RTL and testbench

//  Parametrised multi-port register file for the multicycle core; successor to the single-write/dual-read file.

---
 rtl/regfile_pkg.sv | 26 ++
 rtl/regfile_mp_disp_scanner.sv | 60 ++++++
 rtl/regfile_mp.sv | 100 ++++++++++
 tb/tb_regfile_mp.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_pkg
//  Purpose  : Shared defaults and the byte-enable mask helper for regfile_mp.
//  Revision : 1.0  initial release
// ============================================================================
package regfile_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;
    localparam int DEPTH          = 2**DEFAULT_ADDR_W;

    // Expands one enable bit per byte into a full-width bit mask.
    function automatic logic [DEFAULT_DATA_W-1:0] be_mask(
        input logic [DEFAULT_DATA_W/8-1:0] be
    );
        logic [DEFAULT_DATA_W-1:0] m;
        m = '0;
        for (int b = 0; b < DEFAULT_DATA_W/8; b++) begin
            m[8*b +: 8] = {8{be[b]}};
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_mp_disp_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : disp_scanner
//  Purpose  : Display index sequencer: manual select or prescaled auto-scan.
//  Revision : 1.0  initial release
// ============================================================================
module disp_scanner
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int SCAN_DIV = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              disp_scan,
    input  logic              disp_hold,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [ADDR_W-1:0] idx_next,
    output logic [ADDR_W-1:0] disp_idx
);

    localparam int               PRE_W       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PRE_W-1:0] c_pre_last  = PRE_W'(SCAN_DIV - 1);

    logic [PRE_W-1:0]  r_pre;
    logic [PRE_W-1:0]  w_pre_next;
    logic [ADDR_W-1:0] r_idx;

    // Manual mode parks the prescaler at 0, so a later switch to scan
    // always starts a fresh SCAN_DIV period from the current index.
    always_comb begin
        w_pre_next = r_pre;
        idx_next   = r_idx;
        if (!disp_scan) begin
            w_pre_next = '0;
            idx_next   = disp_addr;
        end else if (!disp_hold) begin
            if (r_pre == c_pre_last) begin
                w_pre_next = '0;
                idx_next   = r_idx + ADDR_W'(1);
            end else begin
                w_pre_next = r_pre + PRE_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre <= '0;
            r_idx <= '0;
        end else begin
            r_pre <= w_pre_next;
            r_idx <= idx_next;
        end
    end

    assign disp_idx = r_idx;

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_mp
//  Purpose  : Multi-port register file with byte-enable writes, optional
//             write-to-read bypass and a registered display port.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int NREAD    = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int SCAN_DIV = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREAD*ADDR_W-1:0] rd_addr,
    output logic [NREAD*DATA_W-1:0] rd_data,
    input  logic                    wr_en,
    input  logic [ADDR_W-1:0]       wr_addr,
    input  logic [DATA_W-1:0]       wr_data,
    input  logic [DATA_W/8-1:0]     wr_be,
    input  logic                    disp_scan,
    input  logic                    disp_hold,
    input  logic [ADDR_W-1:0]       disp_addr,
    output logic [DATA_W-1:0]       disp_data,
    output logic [ADDR_W-1:0]       disp_idx
);

    localparam int REG_COUNT = 2**ADDR_W;

    logic [DATA_W-1:0] r_file [REG_COUNT];
    logic [DATA_W-1:0] r_disp_data;
    logic [DATA_W-1:0] w_mask;
    logic [DATA_W-1:0] w_new;
    logic              w_wr_legal;
    logic [ADDR_W-1:0] w_idx_next;

    generate
        if (DATA_W == DEFAULT_DATA_W) begin : g_mask_pkg
            assign w_mask = be_mask(wr_be);
        end else begin : g_mask_loop
            for (genvar b = 0; b < DATA_W/8; b++) begin : g_byte
                assign w_mask[8*b +: 8] = {8{wr_be[b]}};
            end
        end
    endgenerate

    // Gating with rst_n keeps a write in flight from leaking through the
    // bypass path while reset is asserted.
    assign w_wr_legal = rst_n && wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
    assign w_new      = (r_file[wr_addr] & ~w_mask) | (wr_data & w_mask);

    generate
        for (genvar k = 0; k < NREAD; k++) begin : g_rd
            logic [ADDR_W-1:0] w_addr;
            assign w_addr = rd_addr[k*ADDR_W +: ADDR_W];
            assign rd_data[k*DATA_W +: DATA_W] =
                ((BYPASS != 0) && w_wr_legal && (w_addr == wr_addr)) ? w_new :
                ((ZERO_REG != 0) && (w_addr == '0))                  ? '0    :
                                                                       r_file[w_addr];
        end
    endgenerate

    disp_scanner #(
        .ADDR_W   (ADDR_W),
        .SCAN_DIV (SCAN_DIV)
    ) u_scanner (
        .clk       (clk),
        .rst_n     (rst_n),
        .disp_scan (disp_scan),
        .disp_hold (disp_hold),
        .disp_addr (disp_addr),
        .idx_next  (w_idx_next),
        .disp_idx  (disp_idx)
    );

    // The display samples the array before this edge's write lands, so a
    // write to the shown register reaches disp_data one edge later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_file[i] <= '0;
            end
            r_disp_data <= '0;
        end else begin
            if (w_wr_legal) begin
                r_file[wr_addr] <= w_new;
            end
            r_disp_data <= r_file[w_idx_next];
        end
    end

    assign disp_data = r_disp_data;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_mp
//  Purpose  : Scoreboard bench for regfile_mp, two parameterisations in step.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  rd_addr = '0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [3:0]  wr_be = '0;
    logic        disp_scan = 1'b0;
    logic        disp_hold = 1'b0;
    logic [4:0]  disp_addr = '0;

    logic [63:0] rd_data_a, rd_data_b;
    logic [31:0] disp_data_a, disp_data_b;
    logic [4:0]  disp_idx_a, disp_idx_b;

    always #5 clk = ~clk;

    regfile_mp #(
        .DATA_W(32), .ADDR_W(5), .NREAD(2), .ZERO_REG(1), .BYPASS(1), .SCAN_DIV(2)
    ) dut_a (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_a),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .disp_scan(disp_scan), .disp_hold(disp_hold), .disp_addr(disp_addr),
        .disp_data(disp_data_a), .disp_idx(disp_idx_a)
    );

    regfile_mp #(
        .DATA_W(32), .ADDR_W(5), .NREAD(2), .ZERO_REG(0), .BYPASS(0), .SCAN_DIV(3)
    ) dut_b (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_be(wr_be),
        .disp_scan(disp_scan), .disp_hold(disp_hold), .disp_addr(disp_addr),
        .disp_data(disp_data_b), .disp_idx(disp_idx_b)
    );

    // Reference model: per-instance register contents and display state.
    int          byp  [2] = '{1, 0};
    int          zr   [2] = '{1, 0};
    int          sdiv [2] = '{2, 3};
    logic [31:0] m_file [2][32];
    logic [31:0] m_disp [2];
    int          m_idx  [2];
    int          m_cnt  [2];

    typedef struct {
        int          d;
        int          kind;
        logic [31:0] exp;
    } item_t;
    item_t sb[$];

    int errors = 0;
    int checks = 0;

    function automatic bit write_ok(int d);
        return (rst_n === 1'b1) && (wr_en === 1'b1) && !((zr[d] != 0) && (wr_addr == 5'd0));
    endfunction

    function automatic logic [31:0] merged(int d);
        logic [31:0] v;
        v = m_file[d][wr_addr];
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) v[8*b +: 8] = wr_data[8*b +: 8];
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int r = 0; r < 32; r++) m_file[d][r] = '0;
            m_disp[d] = '0;
            m_idx[d]  = 0;
            m_cnt[d]  = 0;
        end
    endtask

    task automatic model_step();
        int ni;
        for (int d = 0; d < 2; d++) begin
            ni = m_idx[d];
            if (!disp_scan) begin
                ni       = int'(disp_addr);
                m_cnt[d] = 0;
            end else if (!disp_hold) begin
                m_cnt[d] = m_cnt[d] + 1;
                if (m_cnt[d] == sdiv[d]) begin
                    m_cnt[d] = 0;
                    ni       = (m_idx[d] + 1) % 32;
                end
            end
            m_disp[d] = m_file[d][ni];
            m_idx[d]  = ni;
            if (write_ok(d)) m_file[d][wr_addr] = merged(d);
        end
    endtask

    task automatic push_expect();
        item_t       it;
        logic [4:0]  a;
        logic [31:0] e;
        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 2; k++) begin
                a = rd_addr[k*5 +: 5];
                if ((byp[d] != 0) && write_ok(d) && (a == wr_addr)) e = merged(d);
                else if ((zr[d] != 0) && (a == 5'd0))               e = '0;
                else                                                e = m_file[d][a];
                it = '{d: d, kind: k, exp: e};
                sb.push_back(it);
            end
            it = '{d: d, kind: 2, exp: m_disp[d]};
            sb.push_back(it);
            it = '{d: d, kind: 3, exp: 32'(m_idx[d])};
            sb.push_back(it);
        end
    endtask

    function automatic logic [31:0] actual(int d, int kind);
        logic [63:0] rd;
        rd = (d == 0) ? rd_data_a : rd_data_b;
        case (kind)
            0:       return rd[31:0];
            1:       return rd[63:32];
            2:       return (d == 0) ? disp_data_a : disp_data_b;
            default: return {27'd0, (d == 0) ? disp_idx_a : disp_idx_b};
        endcase
    endfunction

    function automatic string kname(int kind);
        case (kind)
            0:       return "rd_data0";
            1:       return "rd_data1";
            2:       return "disp_data";
            default: return "disp_idx";
        endcase
    endfunction

    // Monitor: everything queued for a cycle is compared 2 time units after
    // the falling edge, when inputs and combinational reads have settled.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            while (sb.size() > 0) begin
                item_t       it;
                logic [31:0] act;
                it  = sb.pop_front();
                act = actual(it.d, it.kind);
                checks++;
                if (act !== it.exp) begin
                    errors++;
                    $display("FAIL %s dut%0d @%0t: got %h, expected %h",
                             kname(it.kind), it.d, $time, act, it.exp);
                end
            end
        end
    end

    task automatic cyc(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic [4:0] ra0, input logic [4:0] ra1,
                       input bit scan, input bit hold, input logic [4:0] da);
        @(negedge clk);
        wr_en     = we;
        wr_addr   = wa;
        wr_data   = wd;
        wr_be     = be;
        rd_addr   = {ra1, ra0};
        disp_scan = scan;
        disp_hold = hold;
        disp_addr = da;
        push_expect();
        @(posedge clk);
        model_step();
    endtask

    // Reset pulsed between edges while a write is being presented.
    task automatic reset_pulse();
        @(negedge clk);
        wr_en     = 1'b1;
        wr_addr   = 5'd5;
        wr_data   = 32'hDEADBEEF;
        wr_be     = 4'hF;
        rd_addr   = {5'd5, 5'd5};
        disp_scan = 1'b0;
        disp_addr = 5'd5;
        #1;
        rst_n = 1'b0;
        wr_en = 1'b0;
        model_reset();
        push_expect();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        model_step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit scan_r;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        push_expect();
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        model_step();

        // Full writes, bypass and zero register
        cyc(1, 5'd3, 32'h12345678, 4'hF, 5'd3, 5'd3, 0, 0, 5'd0);
        cyc(0, 5'd0, 32'h0,        4'h0, 5'd3, 5'd3, 0, 0, 5'd0);
        cyc(1, 5'd0, 32'hFFFFFFFF, 4'hF, 5'd0, 5'd3, 0, 0, 5'd0);
        cyc(0, 5'd0, 32'h0,        4'h0, 5'd0, 5'd0, 0, 0, 5'd0);
        // Byte merge
        cyc(1, 5'd7, 32'hAABBCCDD, 4'hF,    5'd7, 5'd1, 0, 0, 5'd0);
        cyc(1, 5'd7, 32'h11223344, 4'b0101, 5'd7, 5'd7, 0, 0, 5'd0);
        cyc(0, 5'd0, 32'h0,        4'h0,    5'd7, 5'd7, 0, 0, 5'd0);
        // Bypass on a single port, then zero byte enables
        cyc(1, 5'd9,  32'h00000055, 4'hF, 5'd9,  5'd2,  0, 0, 5'd0);
        cyc(0, 5'd0,  32'h0,        4'h0, 5'd9,  5'd9,  0, 0, 5'd0);
        cyc(1, 5'd10, 32'hCAFEF00D, 4'h0, 5'd10, 5'd10, 0, 0, 5'd0);
        cyc(0, 5'd0,  32'h0,        4'h0, 5'd10, 5'd10, 0, 0, 5'd0);
        // Manual display and write-through to the shown register
        cyc(1, 5'd4, 32'h00000077, 4'hF, 5'd4, 5'd0, 0, 0, 5'd0);
        cyc(0, 5'd0, 32'h0,        4'h0, 5'd4, 5'd0, 0, 0, 5'd4);
        cyc(1, 5'd4, 32'h00000088, 4'hF, 5'd4, 5'd4, 0, 0, 5'd4);
        cyc(0, 5'd0, 32'h0,        4'h0, 5'd4, 5'd4, 0, 0, 5'd4);
        cyc(0, 5'd0, 32'h0,        4'h0, 5'd4, 5'd4, 0, 0, 5'd4);
        // Scan from 30 through the wrap, with a hold in the middle
        cyc(1, 5'd31, 32'h3131_3131, 4'hF, 5'd0, 5'd0, 0, 0, 5'd30);
        repeat (8) cyc(0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0, 1, 0, 5'd0);
        repeat (3) cyc(0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0, 1, 1, 5'd0);
        repeat (5) cyc(0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0, 1, 0, 5'd0);
        cyc(0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0, 0, 0, 5'd12);
        // Reset in the middle of activity
        cyc(1, 5'd5, 32'hDEADBEEF, 4'hF, 5'd5, 5'd5, 0, 0, 5'd5);
        cyc(0, 5'd0, 32'h0,        4'h0, 5'd5, 5'd5, 1, 0, 5'd5);
        reset_pulse();
        cyc(0, 5'd0, 32'h0, 4'h0, 5'd5, 5'd3, 0, 0, 5'd5);

        // Randomised traffic with addresses biased toward collisions
        scan_r = 1'b0;
        for (int n = 0; n < 400; n++) begin
            logic [4:0] wa, r0, r1;
            if ($urandom_range(0, 15) == 0) scan_r = ~scan_r;
            wa = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom);
            r0 = ($urandom_range(0, 1) == 0) ? wa : 5'($urandom_range(0, 7));
            r1 = 5'($urandom_range(0, 31));
            cyc(bit'($urandom_range(0, 1)), wa, $urandom, 4'($urandom), r0, r1,
                scan_r, ($urandom_range(0, 3) == 0), 5'($urandom_range(0, 31)));
        end

        @(negedge clk);
        #4;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
